// File: rtl/tft_pkg.sv
// Shared TFT definitions: panel command bytes, arbiter state encoding and
// the wrap-around index helper used by the round-robin schedulers.
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2a;
    localparam logic [7:0] CMD_PASET = 8'h2b;
    localparam logic [7:0] CMD_RAMWR = 8'h2c;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    function automatic int wrap_add(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req scanning upward from
// last+1 with wrap, returned both one-hot and as an index.
module rr_pick
    import tft_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic [N-1:0] onehot,
    output logic [2:0]   idx,
    output logic         valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        onehot = '0;
        idx    = last;
        valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!valid && |(req & (N'(1) << wrap_add(int'(last), k, N)))) begin
                onehot = N'(1) << wrap_add(int'(last), k, N);
                idx    = 3'(wrap_add(int'(last), k, N));
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_arbiter.sv
// Round-robin arbiter sharing one TFT byte interface between drawing clients.
// Optional idle-grant timeout enabled by defining TFT_ARB_TIMEOUT_EN.
module tft_arbiter
    import tft_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CLIENTS-1:0]   req,
    output logic [NUM_CLIENTS-1:0]   grant,
    input  logic [NUM_CLIENTS-1:0]   cl_transmit,
    input  logic [NUM_CLIENTS-1:0]   cl_dc,
    input  logic [8*NUM_CLIENTS-1:0] cl_data,
    output logic [NUM_CLIENTS-1:0]   cl_tft_busy,
    input  logic                     tft_busy,
    output logic                     tft_transmit,
    output logic                     tft_dc,
    output logic [7:0]               tft_data,
    output logic [2:0]               grant_id,
    output logic                     arb_active
`ifdef TFT_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_flag
`endif
);

    arb_state_t               state, state_nxt;
    logic [NUM_CLIENTS-1:0]   grant_nxt;
    logic [2:0]               grant_id_nxt;
    logic                     transmit_nxt, dc_nxt;
    logic [7:0]               data_nxt;
    logic [NUM_CLIENTS-1:0]   pick_onehot;
    logic [2:0]               pick_idx;
    logic                     pick_valid;
    logic                     cur_req, cur_transmit, cur_dc;
    logic [7:0]               cur_data;
    logic                     timeout_hit;

    rr_pick #(.N(NUM_CLIENTS)) u_pick (
        .req    (req),
        .last   (grant_id),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // The one-hot grant doubles as the mux select for the owner's signals.
    always_comb begin
        cur_req      = |(req & grant);
        cur_transmit = |(cl_transmit & grant);
        cur_dc       = |(cl_dc & grant);
        cur_data     = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) cur_data = cur_data | cl_data[8*i +: 8];
        end
    end

    always_comb begin
        cl_tft_busy = '1;
        if (state == ARB_GRANT)
            cl_tft_busy = ~grant | {NUM_CLIENTS{tft_busy | tft_transmit}};
    end

    assign arb_active = (state != ARB_IDLE);

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        transmit_nxt = 1'b0;
        dc_nxt       = tft_dc;
        data_nxt     = tft_data;
        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_nxt    = pick_onehot;
                    grant_id_nxt = pick_idx;
                    state_nxt    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                transmit_nxt = cur_transmit;
                if (cur_transmit) begin
                    dc_nxt   = cur_dc;
                    data_nxt = cur_data;
                end
                if (!cur_req || timeout_hit) state_nxt = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                // Wait for the last forwarded byte to be taken by the driver.
                if (!tft_transmit && !tft_busy) begin
                    grant_nxt = '0;
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state        <= ARB_IDLE;
            grant        <= '0;
            grant_id     <= 3'(NUM_CLIENTS - 1);
            tft_transmit <= 1'b0;
            tft_dc       <= 1'b0;
            tft_data     <= 8'h00;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            grant_id     <= grant_id_nxt;
            tft_transmit <= transmit_nxt;
            tft_dc       <= dc_nxt;
            tft_data     <= data_nxt;
        end
    end

`ifdef TFT_ARB_TIMEOUT_EN
    logic [16:0] idle_cnt;

    assign timeout_hit = (state == ARB_GRANT) && !cur_transmit &&
                         (idle_cnt == 17'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else if (state != ARB_GRANT || cur_transmit) begin
            idle_cnt <= '0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt + 17'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_tft_arbiter.sv
// Bench for tft_arbiter: cycle-level ownership model plus directed scenarios
// (single client, contention, drain, isolation, reset, optional timeout).
module tb_tft_arbiter;
    import tft_pkg::*;

    localparam int N = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [N-1:0]   cl_transmit;
    logic [N-1:0]   cl_dc;
    logic [8*N-1:0] cl_data;
    logic [N-1:0]   cl_tft_busy;
    logic           tft_busy;
    logic           tft_transmit;
    logic           tft_dc;
    logic [7:0]     tft_data;
    logic [2:0]     grant_id;
    logic           arb_active;
`ifdef TFT_ARB_TIMEOUT_EN
    logic           timeout_flag;
`endif

    int checks = 0;
    int failures = 0;
    int ff_leaks = 0;

    tft_arbiter #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .cl_transmit  (cl_transmit),
        .cl_dc        (cl_dc),
        .cl_data      (cl_data),
        .cl_tft_busy  (cl_tft_busy),
        .tft_busy     (tft_busy),
        .tft_transmit (tft_transmit),
        .tft_dc       (tft_dc),
        .tft_data     (tft_data),
        .grant_id     (grant_id),
        .arb_active   (arb_active)
`ifdef TFT_ARB_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the TFT, whether they are draining, and what
    // byte the driver last saw.
    int         m_owner = -1;
    int         m_last = N - 1;
    int         m_stall = 0;
    bit         m_drain = 0;
    bit         m_valid = 0;
    logic       m_tx = 0, m_dc = 0, m_flag = 0;
    logic [7:0] m_data = 0;

    task automatic model_step();
        logic old_tx;
        if (!rst) begin
            m_owner = -1; m_last = N - 1; m_drain = 0; m_stall = 0;
            m_tx = 0; m_dc = 0; m_data = 0; m_flag = 0; m_valid = 1;
        end else begin
            old_tx = m_tx;
            m_tx = 0;
            if (m_owner < 0) begin
                m_stall = 0;
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_last = m_owner;
                    end
                end
            end else if (!m_drain) begin
                if (cl_transmit[m_owner]) begin
                    m_tx = 1; m_dc = cl_dc[m_owner]; m_data = cl_data[8*m_owner +: 8];
                    m_stall = 0;
                end else begin
                    m_stall++;
                end
                if (!req[m_owner]) m_drain = 1;
`ifdef TFT_ARB_TIMEOUT_EN
                if (m_stall == TO) begin m_drain = 1; m_flag = 1; end
`endif
            end else if (!old_tx && !tft_busy) begin
                m_owner = -1; m_drain = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    logic [N-1:0] exp_grant, exp_busy;
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            check("grant", 32'(grant), 32'(exp_grant));
            check("grant_id", 32'(grant_id), 32'(m_last));
            check("arb_active", 32'(arb_active), 32'(m_owner >= 0));
            check("tft_transmit", 32'(tft_transmit), 32'(m_tx));
            check("tft_dc", 32'(tft_dc), 32'(m_dc));
            check("tft_data", 32'(tft_data), 32'(m_data));
            if (m_owner >= 0 && !m_drain) begin
                exp_busy = ~exp_grant | ((tft_busy || m_tx) ? exp_grant : '0);
                check("cl_tft_busy", 32'(cl_tft_busy), 32'(exp_busy));
            end
`ifdef TFT_ARB_TIMEOUT_EN
            check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
`endif
            if (tft_transmit && tft_data == 8'hff) ff_leaks++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst = 0; req = r; cl_transmit = '0; cl_dc = '0; cl_data = '0; tft_busy = 0;
        tick(); tick();
        rst = 1;
    endtask

    task automatic send(input int c, input logic dc, input logic [7:0] d);
        int n = 0;
        while (cl_tft_busy[c] && n < 20) begin tick(); n++; end
        if (n >= 20) check("send_wait", 32'(cl_tft_busy[c]), 32'd0);
        cl_transmit[c] = 1; cl_dc[c] = dc; cl_data[8*c +: 8] = d;
        tick();
        cl_transmit[c] = 0;
    endtask

    int order[4] = '{0, 1, 3, 0};

    initial begin
        int n, gap;
        // Reset values
        do_reset('0);
        rst = 0;
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_active", 32'(arb_active), 32'd0);
        check("rst_transmit", 32'(tft_transmit), 32'd0);

        // Single client
        req = 4'b0010; rst = 1;
        tick();
        check("single_grant", 32'(grant), 32'b0010);
        send(1, 1'b0, CMD_CASET);
        check("single_tx0", 32'(tft_transmit), 32'd1);
        check("single_data0", 32'(tft_data), 32'h2a);
        check("single_dc0", 32'(tft_dc), 32'd0);
        check("single_others_busy", 32'(cl_tft_busy & 4'b1101), 32'b1101);
        send(1, 1'b1, 8'h00);
        check("single_tx1", 32'(tft_transmit), 32'd1);
        check("single_data1", 32'(tft_data), 32'h00);
        check("single_dc1", 32'(tft_dc), 32'd1);
        req = '0;
        tick(); tick(); tick();
        check("single_release", 32'(grant), 32'h0);

        // Contention: grant order 0,1,3,0 with one idle cycle between
        do_reset(4'b1011);
        tick();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (grant == '0 && n < 10) begin tick(); n++; end
            check("rr_order", 32'(grant), 32'(1 << order[k]));
            tick(); tick();
            req[order[k]] = 0;
            tick();
            if (k == 0) req[0] = 1;
            n = 0;
            while (grant != '0 && n < 10) begin tick(); n++; end
            if (k < 3) begin
                gap = 0;
                while (grant == '0 && gap < 10) begin tick(); gap++; end
                check("idle_gap", 32'(gap), 32'd1);
            end
        end

        // Drain: client 2 drops req with last strobe in flight, driver busy 5 cycles
        do_reset(4'b0100);
        tick();
        check("drain_grant", 32'(grant), 32'b0100);
        tick();
        cl_transmit[2] = 1; cl_dc[2] = 1; cl_data[23:16] = 8'h55; req = 4'b0010;
        tick();
        check("drain_last_tx", 32'(tft_transmit), 32'd1);
        check("drain_last_data", 32'(tft_data), 32'h55);
        cl_transmit = '0; tft_busy = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("drain_hold", 32'(grant), 32'b0100);
        end
        tft_busy = 0;
        tick();
        check("drain_clear", 32'(grant), 32'h0);
        tick();
        check("drain_next", 32'(grant), 32'b0010);
        req = '0;
        tick(); tick(); tick();

        // Isolation: client 3 strobes 0xff while client 0 owns the TFT
        do_reset(4'b0001);
        tick();
        check("iso_grant", 32'(grant), 32'b0001);
        cl_transmit[3] = 1; cl_data[31:24] = 8'hff;
        tick();
        check("iso_no_tx", 32'(tft_transmit), 32'd0);
        cl_transmit = 4'b1001; cl_data[7:0] = 8'h22;
        tick();
        check("iso_owner_data", 32'(tft_data), 32'h22);
        cl_transmit = '0;
        tick();
        check("iso_leaks", 32'(ff_leaks), 32'd0);
        req = '0;
        tick(); tick(); tick();

        // Reset mid-stream
        do_reset(4'b0010);
        tick();
        for (int i = 0; i < 3; i++) send(1, 1'b1, 8'(8'h40 + i));
        cl_transmit[1] = 1; cl_data[15:8] = 8'h77; req = 4'b0011; rst = 0;
        tick();
        cl_transmit = '0;
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_tx", 32'(tft_transmit), 32'd0);
        check("mid_rst_active", 32'(arb_active), 32'd0);
        rst = 1;
        tick();
        check("mid_rel_grant", 32'(grant), 32'b0001);
        check("mid_rel_tx", 32'(tft_transmit), 32'd0);
        req = '0;
        tick(); tick(); tick();

`ifdef TFT_ARB_TIMEOUT_EN
        // Timeout: client 0 stalls with req high
        do_reset(4'b0011);
        tick();
        check("to_grant", 32'(grant), 32'b0001);
        for (int i = 0; i < 15; i++) tick();
        check("to_flag_early", 32'(timeout_flag), 32'd0);
        tick();
        check("to_flag", 32'(timeout_flag), 32'd1);
        tick();
        check("to_released", 32'(grant), 32'h0);
        tick();
        check("to_next", 32'(grant), 32'b0010);
        req = '0;
        tick(); tick(); tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/tft_arbiter.md
Name: tft_arbiter

Overview:
- Shares the single TFT byte interface (tft_transmit/tft_dc/tft_data, tft_busy) between NUM_CLIENTS drawing blocks, e.g. maze renderer, player sprite and score overlay.
- Each client raises req for a whole drawing transaction (window set, 0x2c, pixel stream). The arbiter grants one client round-robin, forwards its byte strobes to the TFT driver through one register stage, and holds the grant until the client drops req and the byte pipe drains.

Parameters:
- NUM_CLIENTS, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 65536: idle-grant limit. Used only with TFT_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset. 0 = reset, sampled on posedge clk.
- req  input  NUM_CLIENTS  per-client transaction request; level, held for the whole transaction.
- grant  output  NUM_CLIENTS  one-hot grant; connects to the client enable.
- cl_transmit  input  NUM_CLIENTS  per-client byte strobe, 1-cycle pulse.
- cl_dc  input  NUM_CLIENTS  per-client data/command flag.
- cl_data  input  8*NUM_CLIENTS  per-client byte; client i occupies [8i+7:8i].
- cl_tft_busy  output  NUM_CLIENTS  per-client busy view of the TFT.
- tft_busy  input  1  TFT driver busy.
- tft_transmit  output  1  forwarded strobe.
- tft_dc  output  1  forwarded data/command flag.
- tft_data  output  8  forwarded byte.
- grant_id  output  3  index of the current or last granted client.
- arb_active  output  1  high in the GRANT and DRAIN states.

Behaviour:
- Reset (rst=0):
  - state=IDLE; grant, tft_transmit, tft_dc, tft_data and arb_active all 0.
  - grant_id=NUM_CLIENTS-1, so client 0 wins first.
  - Reset mid-transaction abandons it silently; no strobe is issued on the cycle reset is released.
- IDLE:
  - If req != 0, pick the first set req scanning from grant_id+1 with wrap at NUM_CLIENTS.
  - Register grant (one-hot) and grant_id, then go to GRANT.
  - Grant appears 1 cycle after req is sampled. No req keeps the arbiter in IDLE.
- GRANT (client g):
  - cl_tft_busy[g] = tft_busy | tft_transmit (combinational). The client issues only when this is 0, giving the same handshake the clients already use against the driver.
  - For every i != g, cl_tft_busy[i]=1.
  - Each cycle, tft_transmit <= cl_transmit[g]. When cl_transmit[g]=1, tft_dc <= cl_dc[g] and tft_data <= cl_data[g]. Otherwise tft_dc and tft_data hold their values.
  - Latency is exactly 1 cycle, one strobe in gives one strobe out, and tft_transmit is a 1-cycle pulse.
  - Strobes from non-granted clients are ignored and never reach the TFT.
  - When req[g]=0, go to DRAIN. A strobe in that same cycle is still forwarded.
- DRAIN:
  - grant stays asserted and no new strobes are accepted.
  - When tft_transmit=0 and tft_busy=0: grant <= 0, go to IDLE.
  - Re-arbitration happens in the next IDLE cycle, so there is 1 idle cycle between grants. Window commands of different clients never interleave.
- Simultaneous requests: strict round-robin. After g finishes, client g+1 (mod N) has the highest priority.
- A client that re-raises req during its own DRAIN is served only after the other pending clients.
- No grant is ever held by a client whose req is low outside the DRAIN state.

Optional Feature:
- Macro: TFT_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 17-bit counter clears on each forwarded strobe and on grant.
  - It counts cycles in GRANT while cl_transmit[g]=0.
  - When it reaches TIMEOUT_CYCLES, the arbiter forces DRAIN and sets the sticky output timeout_flag (extra port, 1 bit, cleared by reset).
- Without the macro: the counter and the port are absent, and a grant is held indefinitely.

Decomposition:
- Shared package tft_pkg holds:
  - TFT command constants CMD_CASET=8'h2a, CMD_PASET=8'h2b, CMD_RAMWR=8'h2c.
  - Arbiter state encoding ARB_IDLE, ARB_GRANT, ARB_DRAIN.
- One sub-module, rr_pick: combinational round-robin picker taking req and the last index and returning one-hot plus index. It is reusable by other shared-resource schedulers.

Test Plan:
- Single client: req[1]=1, then strobes 0x2a (dc=0) and 0x00 (dc=1).
  - Required: grant=4'b0010 one cycle later.
  - Required: tft_transmit pulses carry identical dc/data 1 cycle after each cl_transmit.
  - Required: cl_tft_busy[0,2,3]=1 throughout.
- Contention: req=4'b1011 from reset.
  - Required grant order: 0, 1, 3, 0.
  - Required: exactly 1 idle cycle (grant=0) between grants.
- Drain: client 2 drops req while the last strobe is in flight and tft_busy=1 for 5 cycles.
  - Required: grant[2] stays high until tft_busy falls, then clears; the next client's grant follows 1 cycle later.
- Isolation: client 3 pulses cl_transmit with data 0xff while client 0 is granted.
  - Required: no tft_transmit is issued with 0xff.
- Reset mid-stream: rst=0 during pixel streaming.
  - Required: the next cycle shows grant=0, tft_transmit=0, arb_active=0; after release, client 0 wins first.
- With TFT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: the granted client stalls with req high.
  - Required: after 16 cycles the arbiter enters DRAIN, timeout_flag=1, and the next requester is granted.
